receive_array: RTL and testbench
================================

RECEIVE_ARRAY -- requirements
Module: receive_array

Interface
REQ-001 SHALL have parameter DELAY_FRAMES, default 234; bit period is DELAY_FRAMES+1 clk cycles (235 at 27 MHz, 115200 baud).
REQ-002 SHALL have parameter N_WORDS, default 20; number of 32-bit words per frame.
REQ-003 SHALL have parameter HEADER_LEN, default 4; header bytes per frame.
REQ-004 SHALL have parameter HEADER_BYTE, default 8'h01; value of every header byte.
REQ-005 SHALL have parameter TIMEOUT_BITS, default 16; max idle bit periods between payload bytes.
REQ-006 clk  input  1  sole clock; all logic on posedge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-009 u_out  output  32*N_WORDS  last complete frame; word i at u_out[i*32+:32].
REQ-010 frame_valid  output  1  one-cycle pulse when u_out is updated.
REQ-011 busy  output  1  high while in PAYLOAD state.
REQ-012 error  output  1  one-cycle pulse on framing error or timeout during PAYLOAD.

Function
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Byte receiver idle: falling edge on synchronized line starts a byte.
REQ-015 Start bit SHALL be resampled (DELAY_FRAMES+1)/2 = 117 cycles after the edge; if high, treat as glitch and return to idle with no output.
REQ-016 Data bits 0..7 SHALL each be sampled DELAY_FRAMES+1 cycles after the previous sample, LSB first.
REQ-017 Stop bit SHALL be sampled one bit period after bit 7.
REQ-018 Stop=1 -> byte_valid pulse for one cycle with the byte.
REQ-019 Stop=0 -> frame_err pulse, byte discarded; the receiver SHALL wait for line high before re-arming.
REQ-020 Frame FSM states: HUNT, PAYLOAD.
REQ-021 HUNT: hdr_cnt SHALL increment on each byte equal to HEADER_BYTE and reset to 0 on any other byte.
REQ-022 HUNT: when hdr_cnt reaches HEADER_LEN, go to PAYLOAD with byte_idx=0; more than HEADER_LEN consecutive header bytes SHALL start payload after exactly HEADER_LEN bytes.
REQ-023 PAYLOAD: byte k SHALL be written to shadow[k*8+:8] (little-endian words); HEADER_BYTE values are ordinary data here.
REQ-024 After byte 4*N_WORDS-1: on the next clk edge, u_out <= full shadow (atomic), frame_valid=1, FSM -> HUNT, hdr_cnt=0.
REQ-025 u_out SHALL never show a partial frame; it holds its value until the next complete frame.
REQ-026 Framing error in PAYLOAD -> error pulse, u_out unchanged, FSM -> HUNT; in HUNT -> hdr_cnt=0, no error pulse.
REQ-027 PAYLOAD idle counter SHALL reset on each byte_valid and abort on TIMEOUT_BITS*(DELAY_FRAMES+1) cycles without a byte: error pulse, FSM -> HUNT.
REQ-028 Timeout and byte completion in the same cycle: byte completion SHALL win.

Reset
REQ-029 rst SHALL set: u_out=0, frame_valid=0, busy=0, error=0, FSM=HUNT, hdr_cnt=0, byte_idx=0, receiver idle, synchronizer flops=1.
REQ-030 rst mid-byte or mid-frame SHALL discard all partial data; the next frame SHALL require a full header.

Structure
REQ-031 A shared package SHALL hold DELAY_FRAMES, N_WORDS, HEADER_LEN, HEADER_BYTE, and the FSM state encoding; the frame transmitter SHALL use the same constants.
REQ-032 One sub-module, uart_rx, SHALL contain the synchronizer and byte receiver (outputs data[7:0], byte_valid, frame_err); receive_array SHALL contain the frame FSM and the shadow/output registers.

Verification
REQ-033 Send 4x 0x01, then words 0..19 = i*0x01010101 -> one frame_valid; u_out[i*32+:32] = i*0x01010101; error never asserted.
REQ-034 Send 0x01,0x01,0x55,0x01x4, then payload of all 0xA5 -> frame accepted only after the second header; u_out = all 0xA5.
REQ-035 Valid frame, then a frame whose byte 10 has stop=0 -> error pulse once; u_out keeps the first frame; a following clean frame is accepted.
REQ-036 Low glitch of 50 cycles on idle line -> no byte_valid; hdr_cnt unchanged.
REQ-037 Header plus 30 payload bytes, then silence -> error 16*235 cycles after the last byte; FSM HUNT; u_out unchanged.
REQ-038 Assert rst at payload byte 40, then send a full frame -> one frame_valid with correct data; u_out reads 0 until then.

Source files
------------

// File: rtl/receive_array_pkg.sv
// Shared constants and state encodings for the framed UART receiver and its
// matching transmitter.
package receive_array_pkg;

    localparam int unsigned DELAY_FRAMES = 234;    // bit period - 1, in clk cycles
    localparam int unsigned N_WORDS      = 20;     // 32-bit words per frame
    localparam int unsigned HEADER_LEN   = 4;      // header bytes per frame
    localparam logic [7:0]  HEADER_BYTE  = 8'h01;  // value of every header byte
    localparam int unsigned TIMEOUT_BITS = 16;     // idle bit periods allowed in payload

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } frame_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/receive_array_uart_rx.sv
// 8N1 byte receiver: two-flop synchronizer, start-bit glitch rejection,
// mid-bit sampling, stop-bit check.
module uart_rx
    import receive_array_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = receive_array_pkg::DELAY_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned BIT_CYC  = DELAY_FRAMES + 1;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic             rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Bring the asynchronous line into the clk domain; keep one extra stage for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    // Byte receiver state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !sync2) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {sync2, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (sync2) begin
                            data       <= shreg;
                            byte_valid <= 1'b1;
                            state      <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (sync2) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/receive_array.sv
// Framed receiver: hunts for a run of header bytes, collects a fixed-size
// payload into a shadow buffer and publishes it atomically on u_out.
module receive_array
    import receive_array_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = receive_array_pkg::DELAY_FRAMES,
    parameter int unsigned N_WORDS      = receive_array_pkg::N_WORDS,
    parameter int unsigned HEADER_LEN   = receive_array_pkg::HEADER_LEN,
    parameter logic [7:0]  HEADER_BYTE  = receive_array_pkg::HEADER_BYTE,
    parameter int unsigned TIMEOUT_BITS = receive_array_pkg::TIMEOUT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [32*N_WORDS-1:0] u_out,
    output logic                 frame_valid,
    output logic                 busy,
    output logic                 error
);

    localparam int unsigned N_BYTES     = 4 * N_WORDS;
    localparam int unsigned TIMEOUT_CYC = TIMEOUT_BITS * (DELAY_FRAMES + 1);
    localparam int unsigned HDR_W       = $clog2(HEADER_LEN + 1);
    localparam int unsigned IDX_W       = $clog2(N_BYTES);
    localparam int unsigned IDLE_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [HDR_W-1:0]  HDR_LAST  = HDR_W'(HEADER_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ferr;

    frame_state_t         state;
    logic [HDR_W-1:0]     hdr_cnt;
    logic [IDX_W-1:0]     byte_idx;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [32*N_WORDS-1:0] shadow;

    uart_rx #(
        .DELAY_FRAMES(DELAY_FRAMES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (uart_rx),
        .data      (rx_data),
        .byte_valid(rx_valid),
        .frame_err (rx_ferr)
    );

    // Frame FSM with shadow buffer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            hdr_cnt     <= '0;
            byte_idx    <= '0;
            idle_cnt    <= '0;
            shadow      <= '0;
            u_out       <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            error       <= 1'b0;
            case (state)
                HUNT: begin
                    if (rx_valid) begin
                        if (rx_data == HEADER_BYTE) begin
                            if (hdr_cnt == HDR_LAST) begin
                                state    <= PAYLOAD;
                                busy     <= 1'b1;
                                hdr_cnt  <= '0;
                                byte_idx <= '0;
                                idle_cnt <= '0;
                            end else begin
                                hdr_cnt <= hdr_cnt + 1'b1;
                            end
                        end else begin
                            hdr_cnt <= '0;
                        end
                    end else if (rx_ferr) begin
                        hdr_cnt <= '0;
                    end
                end
                PAYLOAD: begin
                    // A byte arriving in the timeout cycle takes priority over the abort.
                    if (rx_valid) begin
                        idle_cnt                   <= '0;
                        shadow[{byte_idx, 3'b000} +: 8] <= rx_data;
                        if (byte_idx == IDX_LAST) begin
                            // Final byte is merged straight into u_out so the publish
                            // happens on the edge after its byte_valid.
                            u_out       <= {rx_data, shadow[32*N_WORDS-9:0]};
                            frame_valid <= 1'b1;
                            state       <= HUNT;
                            busy        <= 1'b0;
                            hdr_cnt     <= '0;
                            byte_idx    <= '0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end else if (rx_ferr || idle_cnt == IDLE_LAST) begin
                        error    <= 1'b1;
                        state    <= HUNT;
                        busy     <= 1'b0;
                        hdr_cnt  <= '0;
                        byte_idx <= '0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receive_array.sv
// Directed bench for receive_array: drives 8N1 bytes on uart_rx and checks
// frame publication, header hunting, error handling and reset behaviour.
module tb_receive_array;

    localparam int unsigned DF  = 5;
    localparam int unsigned BIT = DF + 1;
    localparam int unsigned NW  = 20;
    localparam int unsigned NB  = 4 * NW;
    localparam int unsigned HL  = 4;
    localparam int unsigned TB  = 16;
    localparam int unsigned TC  = TB * BIT;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              uart_rx = 1'b1;
    logic [32*NW-1:0]  u_out;
    logic              frame_valid;
    logic              busy;
    logic              error;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [7:0] pl [NB];

    typedef struct {
        logic [31:0] mul;
        logic [31:0] exp_w1;
        logic [31:0] exp_w19;
    } vec_t;
    vec_t tbl [3];

    int unsigned cyc = 0, fv_cnt = 0, err_cnt = 0, bv_cnt = 0, bad_change = 0;
    int unsigned last_bv_cyc = 0, err_cyc = 0;
    logic [32*NW-1:0] prev_u = '0;

    int unsigned f0, e0, b0, d;
    logic [32*NW-1:0] keep;

    receive_array #(
        .DELAY_FRAMES(DF),
        .N_WORDS     (NW),
        .HEADER_LEN  (HL),
        .HEADER_BYTE (8'h01),
        .TIMEOUT_BITS(TB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .u_out      (u_out),
        .frame_valid(frame_valid),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Event counters and u_out stability monitor
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_valid) fv_cnt = fv_cnt + 1;
        if (error) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (dut.u_rx.byte_valid) begin
            bv_cnt      = bv_cnt + 1;
            last_bv_cyc = cyc;
        end
        if (!rst && !frame_valid && u_out !== prev_u) bad_change = bad_change + 1;
        prev_u = u_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input logic [32*NW-1:0] act,
                             input logic [32*NW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop_ok) repeat (BIT) @(negedge clk);
    endtask

    task automatic send_header(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) send_byte(8'h01, 1'b1);
    endtask

    task automatic send_payload(input int unsigned first, input int unsigned last);
        for (int unsigned k = first; k < last; k++) send_byte(pl[k], 1'b1);
    endtask

    function automatic void fill_mul(input logic [31:0] mul);
        logic [31:0] w;
        for (int unsigned i = 0; i < NW; i++) begin
            w = i * mul;
            for (int unsigned j = 0; j < 4; j++) pl[4*i+j] = w[8*j +: 8];
        end
    endfunction

    function automatic void fill_const(input logic [7:0] b);
        for (int unsigned k = 0; k < NB; k++) pl[k] = b;
    endfunction

    function automatic logic [32*NW-1:0] exp_frame();
        logic [32*NW-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < NB; k++) v[k*8 +: 8] = pl[k];
        return v;
    endfunction

    initial begin
        tbl[0] = '{mul: 32'h01010101, exp_w1: 32'h01010101, exp_w19: 32'h13131313};
        tbl[1] = '{mul: 32'h10203040, exp_w1: 32'h10203040, exp_w19: 32'h326394C0};
        tbl[2] = '{mul: 32'hFFFFFFFF, exp_w1: 32'hFFFFFFFF, exp_w19: 32'hFFFFFFED};

        // Reset state
        repeat (5) @(negedge clk);
        chk_frame("reset_u_out", u_out, '0);
        chk("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        chk("reset_hdr_cnt", 32'(dut.hdr_cnt), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Table of complete frames, word i = i * mul
        for (int t = 0; t < 3; t++) begin
            fill_mul(tbl[t].mul);
            f0 = fv_cnt;
            e0 = err_cnt;
            send_header(HL);
            send_byte(pl[0], 1'b1);
            chk($sformatf("t%0d_busy_in_payload", t), {31'd0, busy}, 32'd1);
            send_payload(1, NB);
            repeat (4) @(negedge clk);
            chk($sformatf("t%0d_frame_valid_count", t), fv_cnt - f0, 32'd1);
            chk($sformatf("t%0d_error_count", t), err_cnt - e0, 32'd0);
            chk($sformatf("t%0d_busy_after", t), {31'd0, busy}, 32'd0);
            chk($sformatf("t%0d_word1", t), u_out[32 +: 32], tbl[t].exp_w1);
            chk($sformatf("t%0d_word19", t), u_out[19*32 +: 32], tbl[t].exp_w19);
            chk_frame($sformatf("t%0d_frame", t), u_out, exp_frame());
        end

        // Six header bytes: payload starts after the fourth
        fill_const(8'h22);
        pl[0] = 8'h01;
        pl[1] = 8'h01;
        f0 = fv_cnt;
        send_header(HL);
        send_payload(0, NB);
        repeat (4) @(negedge clk);
        chk("long_hdr_fv", fv_cnt - f0, 32'd1);
        chk("long_hdr_word0", u_out[31:0], 32'h22220101);
        chk("long_hdr_word19", u_out[19*32 +: 32], 32'h22222222);

        // Broken header run, then a real one
        fill_const(8'hA5);
        f0 = fv_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (2) @(negedge clk);
        chk("hdr_reset_on_other", 32'(dut.hdr_cnt), 32'd0);
        send_header(HL);
        repeat (2) @(negedge clk);
        chk("hdr_busy", {31'd0, busy}, 32'd1);
        send_payload(0, NB);
        repeat (4) @(negedge clk);
        chk("resync_fv", fv_cnt - f0, 32'd1);
        chk("resync_word7", u_out[7*32 +: 32], 32'hA5A5A5A5);
        chk_frame("resync_frame", u_out, exp_frame());

        // Short low glitch between header bytes is ignored
        for (int unsigned k = 0; k < NB; k++) pl[k] = 8'(k);
        send_header(2);
        repeat (2) @(negedge clk);
        b0 = bv_cnt;
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_no_byte", bv_cnt - b0, 32'd0);
        chk("glitch_hdr_cnt", 32'(dut.hdr_cnt), 32'd2);
        f0 = fv_cnt;
        send_header(2);
        send_payload(0, NB);
        repeat (4) @(negedge clk);
        chk("glitch_frame_fv", fv_cnt - f0, 32'd1);
        chk_frame("glitch_frame", u_out, exp_frame());
        keep = exp_frame();

        // Stop-bit error on payload byte 10
        for (int unsigned k = 0; k < NB; k++) pl[k] = 8'h80 + 8'(k);
        f0 = fv_cnt;
        e0 = err_cnt;
        send_header(HL);
        send_payload(0, 10);
        send_byte(pl[10], 1'b0);
        repeat (2) @(negedge clk);
        chk("ferr_busy", {31'd0, busy}, 32'd0);
        send_payload(11, NB);
        repeat (4) @(negedge clk);
        chk("ferr_error_count", err_cnt - e0, 32'd1);
        chk("ferr_no_fv", fv_cnt - f0, 32'd0);
        chk_frame("ferr_u_out_kept", u_out, keep);
        fill_mul(32'h00000003);
        f0 = fv_cnt;
        send_header(HL);
        send_payload(0, NB);
        repeat (4) @(negedge clk);
        chk("after_ferr_fv", fv_cnt - f0, 32'd1);
        chk_frame("after_ferr_frame", u_out, exp_frame());
        keep = exp_frame();

        // Payload timeout after 30 bytes
        fill_const(8'h33);
        f0 = fv_cnt;
        e0 = err_cnt;
        send_header(HL);
        send_payload(0, 30);
        for (int i = 0; i < int'(TC + 4 * BIT); i++) begin
            if (err_cnt != e0) break;
            @(negedge clk);
        end
        chk("timeout_error", err_cnt - e0, 32'd1);
        d = err_cyc - last_bv_cyc;
        n_tests++;
        if (err_cnt == e0 || d < TC || d > TC + 1) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d", d, TC, TC + 1);
        end
        repeat (2) @(negedge clk);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_no_fv", fv_cnt - f0, 32'd0);
        chk_frame("timeout_u_out_kept", u_out, keep);

        // Reset in the middle of payload byte 40
        for (int unsigned k = 0; k < NB; k++) pl[k] = ~8'(k);
        send_header(HL);
        send_payload(0, 40);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (3 * BIT) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (2 * BIT) @(negedge clk);
        chk_frame("rst_u_out_zero", u_out, '0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hdr_cnt", 32'(dut.hdr_cnt), 32'd0);
        fill_mul(32'h11111111);
        f0 = fv_cnt;
        send_header(HL);
        send_payload(0, NB);
        repeat (4) @(negedge clk);
        chk("rst_next_fv", fv_cnt - f0, 32'd1);
        chk_frame("rst_next_frame", u_out, exp_frame());

        chk("u_out_atomic", bad_change, 32'd0);
        chk("error_total", err_cnt, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
